// File: rtl/output_queue.sv
// rtl/output_queue.sv - DEPTH-entry FIFO for placement results with registered first-word-fall-through head
module output_queue #(
   parameter int COORD_W  = 8,
   parameter int STRIKE_W = 4,
   parameter int DEPTH    = 4,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [COORD_W-1:0]  x_in,
   input  logic [COORD_W-1:0]  y_in,
   input  logic [STRIKE_W-1:0] strike_in,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [COORD_W-1:0]  x_out,
   output logic [COORD_W-1:0]  y_out,
   output logic [STRIKE_W-1:0] strike_out,
   output logic [CNT_W-1:0]    count,
   output logic                overflow
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int ENTRY_W = 2 * COORD_W + STRIKE_W;

   // Entries are packed as {x, y, strike} throughout.
   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [ENTRY_W-1:0] head_q, head_d;
   logic [ENTRY_W-1:0] in_entry;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;
   logic               push, pop;
   logic               full, empty;

   assign in_entry = {x_in, y_in, strike_in};
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);

   // Handshakes are decoded from registered state only, so no input reaches an output.
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid && !full && !flush;
   assign pop       = out_valid && out_ready && !flush;

   assign x_out      = head_q[ENTRY_W-1 -: COORD_W];
   assign y_out      = head_q[STRIKE_W +: COORD_W];
   assign strike_out = head_q[STRIKE_W-1:0];
   assign count      = count_q;
   assign overflow   = overflow_q;

   // Next-state for pointers, occupancy, overflow and the head register.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      head_d     = head_q;
      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
         head_d     = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         if (in_valid && full) begin
            overflow_d = 1'b1;
         end
         // Reload the head when it was consumed or the queue was empty. The new
         // head slot is being written this edge only when it equals the write
         // pointer, in which case the incoming entry bypasses the array.
         if ((count_d != '0) && (pop || empty)) begin
            if (push && (rd_ptr_d == wr_ptr_q)) begin
               head_d = in_entry;
            end else begin
               head_d = mem_q[rd_ptr_d];
            end
         end
      end
   end

   // Control and head registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         head_q     <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         head_q     <= head_d;
      end
   end

   // Storage array; contents are only read after being written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

endmodule

// File: doc/output_queue.md
Name: output_queue

Overview:
- Parametrised successor to the single-stage x/y/strike output register.
- Buffers placement results (x, y, strike) in a DEPTH-entry FIFO with valid/ready handshakes on both sides.
- Provides registered, first-word-fall-through outputs, an occupancy count, a sticky overflow flag and a synchronous flush.
- Sits between the placement core and the downstream consumer or host interface, so the core is not stalled by short consumer back-pressure.

Parameters:
- COORD_W, 8, width of x and y coordinates.
- STRIKE_W, 4, width of the strike field.
- DEPTH, 4, number of entries. Must be a power of two, ≥2. Output register counts as one entry.
- CNT_W, $clog2(DEPTH+1), width of the count output (derived; not to be overridden).

Ports:
- clk  input  1  Single clock. All state updates on the rising edge.
- rst  input  1  Asynchronous, active-high reset.
- flush  input  1  Synchronous clear of all contents.
- in_valid  input  1  Producer presents an entry.
- in_ready  output  1  Queue can accept an entry this cycle.
- x_in  input  COORD_W  Entry x coordinate.
- y_in  input  COORD_W  Entry y coordinate.
- strike_in  input  STRIKE_W  Entry strike count.
- out_valid  output  1  Head entry is valid.
- out_ready  input  1  Consumer takes the head entry this cycle.
- x_out  output  COORD_W  Head x, driven from a register.
- y_out  output  COORD_W  Head y, driven from a register.
- strike_out  output  STRIKE_W  Head strike, driven from a register.
- count  output  CNT_W  Number of valid entries, 0..DEPTH.
- overflow  output  1  Sticky flag: an entry was dropped.

Behaviour:
- Reset (rst=1, asynchronous) forces:
  - x_out=0, y_out=0, strike_out=0;
  - out_valid=0, count=0, overflow=0;
  - read and write pointers to 0;
  - in_ready=1 once rst deasserts. Assertion mid-transfer discards all contents immediately.
- in_ready = (count != DEPTH). It is decoded from registered count only and does not depend on out_ready in the same cycle.
- Push: occurs when in_valid && in_ready at a rising edge.
- Pop: occurs when out_valid && out_ready at a rising edge.
- out_valid = (count != 0).
- x_out, y_out and strike_out always show the oldest entry and are registered. There is no combinational path from any input to any output.
- Latency: an entry pushed into an empty queue at edge N gives out_valid=1 with that data after edge N, i.e. visible in cycle N+1.
- Back-pressure: while out_valid=1 and out_ready=0, x_out, y_out and strike_out hold stable.
- Pop with entries remaining: the next-oldest entry loads into the output registers on the same edge, so back-to-back pops sustain one entry per cycle.
- Last entry popped with no simultaneous push: out_valid falls and the data outputs hold their last value.
- Simultaneous push and pop:
  - count 1..DEPTH-1: count is unchanged and ordering is preserved.
  - count==1: the pushed entry moves directly into the output registers.
  - Full (count==DEPTH): in_ready=0, so no push can happen. A pop lowers count to DEPTH-1 and in_ready rises in the next cycle.
- Count update: count += push, count -= pop. Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Overflow:
  - in_valid=1 while in_ready=0 drops the entry and sets overflow at that edge.
  - overflow stays set until rst or flush, and has no other effect on operation.
- Flush (synchronous, at the edge where flush=1):
  - sets count=0, out_valid=0 and pointers to 0;
  - clears overflow and zeroes x_out, y_out and strike_out.
- Flush priority:
  - Flush overrides any push or pop in the same cycle.
  - The coincident in_valid is discarded and does not set overflow.
  - in_ready is 1 in the following cycle.
- The output contract is the same as the previous register stage when the queue is never full.

Test Plan:
- Reset, then push x=0x12, y=0x34, strike=0x5 with out_ready=1 -> out_valid=1 one cycle later with 0x12/0x34/0x5. Popped next edge, then count=0.
- out_ready=0, push 4 entries (x=1..4) -> count=4, in_ready=0. A 5th push (x=5) sets overflow=1 and x=5 is never output.
- From full, out_ready=1 for 4 cycles -> x_out sequence 1,2,3,4 on consecutive cycles, then out_valid=0 and count=0.
- count=2, push and pop in the same cycle for 6 cycles -> count stays 2 and output order matches push order, including pointer wrap past entry 3.
- count=3, overflow=1, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, overflow=0, outputs 0, in_ready=1.
- Assert rst asynchronously mid-cycle with count=2 -> all outputs go to 0 before the next edge. After deassert, the first push appears with 1-cycle latency.
